// File: rtl/alt_vipcti121_cdc_xfer_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alt_vipcti121_cdc_xfer_arbiter_pkg
// Brief    : Shared FSM encoding and helper functions for the CDC transfer
//            arbiter.
// Revision : 1.0
// ============================================================================
package alt_vipcti121_cdc_xfer_arbiter_pkg;

    localparam int c_max_req = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DONE     = 2'd3
    } xfer_state_t;

    function automatic int cnt_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

    // One-hot winner: first set request searching upward from last_grant+1, wrapping at num_req.
    function automatic logic [c_max_req-1:0] rr_next_grant(
        input logic [c_max_req-1:0] req,
        input int unsigned          last_grant,
        input int unsigned          num_req
    );
        logic [c_max_req-1:0] gnt;
        logic                 found;
        logic [2:0]           idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= c_max_req; k++) begin
            if (k <= num_req) begin
                idx = 3'((last_grant + k) % num_req);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alt_vipcti121_cdc_xfer_arbiter_ack_sync.sv
`default_nettype none
// ============================================================================
// Module   : alt_vipcti121_cdc_ack_sync
// Brief    : Two-flop synchronizer for the returned ack toggle, with a
//            zero-delay bypass when both domains share one clock.
// Revision : 1.0
// ============================================================================
module alt_vipcti121_cdc_ack_sync #(
    parameter int CLOCKS_ARE_SAME = 0
) (
    input  logic sync_clock,
    input  logic rst,
    input  logic ack_toggle_async,
    output logic ack_sync
);

    generate
        if (CLOCKS_ARE_SAME != 0) begin : g_bypass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = sync_clock ^ rst;
            assign ack_sync         = ack_toggle_async;
        end else begin : g_sync
            (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
            logic r_meta;
            (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
            logic r_sync;

            always_ff @(posedge sync_clock or posedge rst) begin
                if (rst) begin
                    r_meta <= 1'b0;
                    r_sync <= 1'b0;
                end else begin
                    r_meta <= ack_toggle_async;
                    r_sync <= r_meta;
                end
            end

            assign ack_sync = r_sync;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/alt_vipcti121_cdc_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alt_vipcti121_cdc_xfer_arbiter
// Brief    : Round-robin arbiter sharing one toggle-handshake clock-crossing
//            channel between NUM_REQ control-register requesters.
// Revision : 1.0
// ============================================================================
module alt_vipcti121_cdc_xfer_arbiter
    import alt_vipcti121_cdc_xfer_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CLOCKS_ARE_SAME = 0
) (
    input  logic                          sync_clock,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         xfer_data,
    output logic                          xfer_toggle,
    input  logic                          ack_toggle_async,
    output logic                          timeout_err,
    input  logic                          clear_err
);

    localparam int                 c_cnt_w   = cnt_width(TIMEOUT_CYCLES);
    localparam int                 c_idx_w   = $clog2(NUM_REQ);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_pre = c_cnt_w'(TIMEOUT_CYCLES - 1);

    xfer_state_t             r_state;
    xfer_state_t             w_state_nxt;
    logic [NUM_REQ-1:0]      r_grant;
    logic [c_idx_w-1:0]      r_last_grant;
    logic [c_idx_w-1:0]      w_grant_idx;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_toggle;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [c_max_req-1:0]    w_req_ext;
    logic [c_max_req-1:0]    w_rr;
    logic                    w_rr_unused;
    logic                    w_ack_sync;
    logic                    w_ack_match;
    logic                    w_timeout_evt;

    alt_vipcti121_cdc_ack_sync #(
        .CLOCKS_ARE_SAME (CLOCKS_ARE_SAME)
    ) u_ack_sync (
        .sync_clock       (sync_clock),
        .rst              (rst),
        .ack_toggle_async (ack_toggle_async),
        .ack_sync         (w_ack_sync)
    );

    always_comb begin
        w_req_ext              = '0;
        w_req_ext[NUM_REQ-1:0] = req;
    end

    assign w_rr        = rr_next_grant(w_req_ext, 32'(r_last_grant), NUM_REQ);
    assign w_rr_unused = ^w_rr;

    always_comb begin
        w_grant_idx = '0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_grant_idx = c_idx_w'(i);
                w_sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Equality (not edge) compare: a stale ack left over from IDLE resolves itself at the next launch.
    assign w_ack_match   = (w_ack_sync == r_toggle);
    assign w_timeout_evt = (r_state == ST_WAIT_ACK) && !w_ack_match && (r_cnt == c_cnt_pre);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (|req) w_state_nxt = ST_LAUNCH;
            ST_LAUNCH:   w_state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: if (w_ack_match) w_state_nxt = ST_DONE;
            ST_DONE:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sync_clock or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_idx_w'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_toggle     <= 1'b0;
            r_err        <= 1'b0;
            r_data       <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_grant <= w_rr[NUM_REQ-1:0];
                end
                ST_LAUNCH: begin
                    r_data   <= w_sel_data;
                    r_toggle <= ~r_toggle;
                    r_cnt    <= '0;
                end
                ST_WAIT_ACK: begin
                    // Keep waiting after a timeout so a late ack cannot be mistaken for the next transfer's.
                    if (!w_ack_match && (r_cnt != c_cnt_max)) begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                ST_DONE: begin
                    r_last_grant <= w_grant_idx;
                    r_grant      <= '0;
                end
                default: r_grant <= '0;
            endcase

            if (w_timeout_evt) begin
                r_err <= 1'b1;
            end else if (clear_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign grant       = r_grant;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE) ? r_grant : '0;
    assign xfer_data   = r_data;
    assign xfer_toggle = r_toggle;
    assign timeout_err = r_err;

endmodule
`default_nettype wire
